dmem_arbiter: RTL and testbench

Controller and arbiter for the 10×16 data memory of the pipelined CPU. After reset it runs a button-driven preload sequence:
- each debounced press of `btn_load` writes the switch word to the next address;
- a one-hot LED bar shows which address is pending.

Once all words are loaded, it releases the CPU. The memory write port then belongs to the MEM stage. The read port is shared between the MEM stage and a display reader, with the MEM stage having priority.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory controller: debounced button preload of DEPTH words, then hands the
// write port to the CPU MEM stage and arbitrates the read port against a display reader.
module dmem_arbiter #(
  parameter int DEPTH     = 10,
  parameter int AW        = 4,
  parameter int DW        = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn_load,
  input  logic [DW-1:0]    sw_data,
  input  logic             cpu_mem_write,
  input  logic             cpu_mem_read,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  input  logic             disp_req,
  input  logic [AW-1:0]    disp_addr,
  output logic [DW-1:0]    disp_data,
  output logic             disp_valid,
  output logic             mem_we,
  output logic [AW-1:0]    mem_waddr,
  output logic [DW-1:0]    mem_wdata,
  output logic [AW-1:0]    mem_raddr,
  input  logic [DW-1:0]    mem_rdata,
  output logic             cpu_run,
  output logic [DEPTH-1:0] load_led,
  output logic             load_done,
  output logic             addr_err
);

  // state  | meaning
  // S_LOAD | preload via button presses, CPU held, CPU requests ignored
  // S_RUN  | CPU owns the write port; terminal until reset
  typedef enum logic {S_LOAD, S_RUN} state_t;

  localparam int               CW       = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]    DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    DEPTH_A  = AW'(DEPTH);
  localparam logic [DEPTH-1:0] LED_INIT = {1'b1, {(DEPTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [AW-1:0]    load_ptr_q, load_ptr_d;
  logic [DEPTH-1:0] load_led_q, load_led_d;
  logic             load_done_q, load_done_d;
  logic             cpu_run_q, cpu_run_d;

  logic             btn_s1_q, btn_s2_q;
  logic             btn_lvl_q, btn_lvl_prev_q;
  logic [CW-1:0]    db_cnt_q;
  logic             load_stb_q;

  logic             disp_valid_q;
  logic [DW-1:0]    disp_data_q;
  logic             addr_err_q;

  logic             cpu_legal, disp_legal, cpu_rd, disp_grant, in_run;

  // Synchronizer, debounce and rising-edge strobe of the accepted level
  always_ff @(posedge clk) begin
    if (!clr) begin
      btn_s1_q       <= 1'b0;
      btn_s2_q       <= 1'b0;
      btn_lvl_q      <= 1'b0;
      btn_lvl_prev_q <= 1'b0;
      db_cnt_q       <= '0;
      load_stb_q     <= 1'b0;
    end else begin
      btn_s1_q       <= btn_load;
      btn_s2_q       <= btn_s1_q;
      btn_lvl_prev_q <= btn_lvl_q;
      load_stb_q     <= btn_lvl_q & ~btn_lvl_prev_q;
      if (btn_s2_q == btn_lvl_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        btn_lvl_q <= btn_s2_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign in_run     = (state_q == S_RUN);
  assign cpu_legal  = (cpu_addr < DEPTH_A);
  assign disp_legal = (disp_addr < DEPTH_A);
  assign cpu_rd     = in_run & cpu_mem_read;
  assign disp_grant = ~cpu_rd & disp_req & ~disp_valid_q;
  assign mem_raddr  = cpu_rd ? cpu_addr : disp_addr;
  assign cpu_rdata  = (cpu_rd & cpu_legal) ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    load_led_d  = load_led_q;
    load_done_d = load_done_q;
    cpu_run_d   = cpu_run_q;
    mem_we      = 1'b0;
    mem_waddr   = load_ptr_q;
    mem_wdata   = sw_data;
    case (state_q)
      S_LOAD: begin
        if (load_stb_q) begin
          mem_we     = 1'b1;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == PTR_LAST) begin
            state_d     = S_RUN;
            load_led_d  = LED_INIT;
            load_done_d = 1'b1;
            cpu_run_d   = 1'b1;
          end else begin
            load_led_d = load_led_q >> 1;
          end
        end
      end
      S_RUN: begin
        mem_we    = cpu_mem_write & cpu_legal;
        mem_waddr = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= S_LOAD;
      load_ptr_q   <= '0;
      load_led_q   <= LED_INIT;
      load_done_q  <= 1'b0;
      cpu_run_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      load_led_q   <= load_led_d;
      load_done_q  <= load_done_d;
      cpu_run_q    <= cpu_run_d;
      disp_valid_q <= disp_grant;
      if (disp_grant) disp_data_q <= disp_legal ? mem_rdata : '0;
      addr_err_q   <= in_run & (cpu_mem_read | cpu_mem_write) & ~cpu_legal;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign addr_err   = addr_err_q;
  assign cpu_run    = cpu_run_q;
  assign load_led   = load_led_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: external memory model, queued expectations for writes,
// display reads and address errors, checked by a negedge monitor.
module tb_dmem_arbiter;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        clr, btn_load, cpu_mem_write, cpu_mem_read, disp_req;
  logic [15:0] sw_data, cpu_wdata, cpu_rdata, disp_data, mem_wdata, mem_rdata;
  logic [3:0]  cpu_addr, disp_addr, mem_waddr, mem_raddr;
  logic        disp_valid, mem_we, cpu_run, load_done, addr_err;
  logic [9:0]  load_led;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(10), .AW(4), .DW(16), .DB_CYCLES(DB)) dut (
    .clk(clk), .clr(clr), .btn_load(btn_load), .sw_data(sw_data),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_read(cpu_mem_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .load_led(load_led), .load_done(load_done),
    .addr_err(addr_err)
  );

  // Memory array, 16 entries so illegal addresses return junk the DUT must mask
  logic [15:0] mem [0:15];
  logic [15:0] ref_mem [0:15];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cyc; logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [15:0] data; } rd_t;
  wr_t wq[$];
  rd_t dq[$];
  int  eq[$];
  wr_t we_e;
  rd_t de;
  int  ee;

  int checks = 0, errors = 0, we_cnt = 0;
  int k = 0;
  logic [3:0] ptr_m = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (wq.size() == 0) unexpected("mem_we");
      else begin
        we_e = wq.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(we_e.cyc));
        chk("wr_addr", 32'(mem_waddr), 32'(we_e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(we_e.data));
      end
    end
    if (disp_valid === 1'b1) begin
      if (dq.size() == 0) unexpected("disp_valid");
      else begin
        de = dq.pop_front();
        chk("disp_cycle", 32'(cyc), 32'(de.cyc));
        chk("disp_data", 32'(disp_data), 32'(de.data));
      end
    end
    if (addr_err === 1'b1) begin
      if (eq.size() == 0) unexpected("addr_err");
      else begin
        ee = eq.pop_front();
        chk("err_cycle", 32'(cyc), 32'(ee));
      end
    end
  end

  function automatic logic [9:0] led_exp(input int n);
    logic [9:0] one;
    one = 10'd1;
    return one << (9 - (n % 10));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Held from the cycle after edge m; first synchronizer sample at m+1, write seen at m+3+DB
  task automatic press(input logic [15:0] d, input int hold, input bit exp_wr);
    step();
    sw_data  = d;
    btn_load = 1'b1;
    if (exp_wr) begin
      wq.push_back('{cyc + 3 + DB, ptr_m, d});
      ref_mem[ptr_m] = d;
      ptr_m = ptr_m + 4'd1;
    end
    repeat (hold) step();
    btn_load = 1'b0;
    repeat (12) step();
  endtask

  logic        wr, rd, dpend, served_last, grant;
  logic [3:0]  a, daddr;
  logic [15:0] wd, exp_rd;

  initial begin
    clr = 1'b0; btn_load = 1'b0; sw_data = '0;
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b0; disp_addr = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 16'hE000 | 16'(i);
      ref_mem[i] = 16'hE000 | 16'(i);
    end
    repeat (3) step();
    chk("rst_led", 32'(load_led), 32'h200);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_dvalid", 32'(disp_valid), 32'd0);
    chk("rst_ddata", 32'(disp_data), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    clr = 1'b1;

    // CPU traffic during LOAD must be ignored
    cpu_mem_write = 1'b1; cpu_mem_read = 1'b1; cpu_addr = 4'd1; cpu_wdata = 16'hFFFF;

    repeat (3) begin
      step(); btn_load = 1'b1;
      repeat (3) step(); btn_load = 1'b0;
      repeat (6) step();
    end
    chk("glitch_no_write", 32'(we_cnt), 32'd0);

    press(16'h1000, 50, 1'b1);
    k = 1;
    chk("led_after_1", 32'(load_led), 32'(led_exp(k)));
    for (int i = 1; i < 10; i++) begin
      if (i == 9) begin
        cpu_mem_write = 1'b0; cpu_mem_read = 1'b0;
      end
      press(16'h1000 + 16'(i), 8, 1'b1);
      k++;
      chk("led_walk", 32'(load_led), 32'(led_exp(k)));
      if (i == 4) begin
        step();
        disp_req = 1'b1; disp_addr = 4'd2;
        dq.push_back('{cyc + 1, ref_mem[2]});
        @(negedge clk);
        chk("load_cpu_rdata", 32'(cpu_rdata), 32'd0);
        step();
        disp_req = 1'b0;
        step();
      end
    end
    chk("run_after_load", 32'(cpu_run), 32'd1);
    chk("done_after_load", 32'(load_done), 32'd1);
    chk("preload_we_count", 32'(we_cnt), 32'd10);
    for (int i = 0; i < 10; i++) chk("preload_mem", 32'(mem[i]), 32'h1000 + 32'(i));

    press(16'h5555, 8, 1'b0);
    chk("led_run_press", 32'(load_led), 32'h200);

    step();
    cpu_mem_write = 1'b1; cpu_addr = 4'd3; cpu_wdata = 16'hBEEF;
    wq.push_back('{cyc, 4'd3, 16'hBEEF});
    ref_mem[3] = 16'hBEEF;
    step();
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 4'd3;
    @(negedge clk);
    chk("rd_beef", 32'(cpu_rdata), 32'hBEEF);
    step();
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 4'd12; cpu_wdata = 16'h1234;
    eq.push_back(cyc + 1);
    step();
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 4'd15;
    eq.push_back(cyc + 1);
    @(negedge clk);
    chk("rd_illegal", 32'(cpu_rdata), 32'd0);
    step();
    cpu_mem_read = 1'b0;
    repeat (2) step();

    // Display request blocked by four CPU reads
    disp_req = 1'b1; disp_addr = 4'd5; cpu_mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 4'(i * 2);
      @(negedge clk);
      chk("contend_rdata", 32'(cpu_rdata), 32'(ref_mem[i * 2]));
      step();
    end
    cpu_mem_read = 1'b0;
    dq.push_back('{cyc + 1, ref_mem[5]});
    step();
    disp_req = 1'b0;
    repeat (2) step();

    // Held request is re-served every other cycle
    disp_req = 1'b1; disp_addr = 4'd7;
    dq.push_back('{cyc + 1, ref_mem[7]});
    dq.push_back('{cyc + 3, ref_mem[7]});
    dq.push_back('{cyc + 5, ref_mem[7]});
    repeat (5) step();
    disp_req = 1'b0;
    repeat (3) step();

    dpend = 1'b0; served_last = 1'b0; daddr = '0;
    for (int t = 0; t < 400; t++) begin
      step();
      wr = ($urandom_range(3, 0) == 0);
      rd = ($urandom_range(4, 0) < 2);
      a  = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9, 0));
      wd = 16'($urandom);
      if (!dpend && $urandom_range(2, 0) == 0) begin
        dpend = 1'b1;
        daddr = 4'($urandom_range(15, 0));
      end
      cpu_mem_write = wr; cpu_mem_read = rd; cpu_addr = a; cpu_wdata = wd;
      disp_req = dpend; disp_addr = daddr;
      grant = dpend && !rd && !served_last;
      if (grant) begin
        dq.push_back('{cyc + 1, (daddr < 4'd10) ? ref_mem[daddr] : 16'h0});
        dpend = 1'b0;
      end
      served_last = grant;
      exp_rd = (a < 4'd10) ? ref_mem[a] : 16'h0;
      if ((rd || wr) && a >= 4'd10) eq.push_back(cyc + 1);
      if (wr && a < 4'd10) begin
        wq.push_back('{cyc, a, wd});
        ref_mem[a] = wd;
      end
      if (rd) begin
        @(negedge clk);
        chk("rand_rdata", 32'(cpu_rdata), 32'(exp_rd));
      end
    end
    step();
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b0; disp_req = 1'b0;
    repeat (4) step();

    clr = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    ptr_m = 4'd0; k = 0;
    chk("rerst_led", 32'(load_led), 32'h200);
    chk("rerst_run", 32'(cpu_run), 32'd0);
    for (int i = 0; i < 4; i++) press(16'h2000 + 16'(i), 8, 1'b1);
    chk("led_after_4", 32'(load_led), 32'(led_exp(4)));
    clr = 1'b0;
    step();
    clr = 1'b1;
    ptr_m = 4'd0;
    chk("midload_led", 32'(load_led), 32'h200);
    chk("midload_done", 32'(load_done), 32'd0);
    press(16'h3000, 8, 1'b1);
    chk("midload_led_1", 32'(load_led), 32'(led_exp(1)));
    chk("midload_mem0", 32'(mem[0]), 32'h3000);
    chk("midload_mem3_kept", 32'(mem[3]), 32'h2003);

    repeat (10) step();
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("eq_empty", 32'(eq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
